// File: rtl/cpu_types_pkg.sv
// Shared types for the instruction cache.
// Holds the address-field split used at the default frame count, plus the fill FSM states.
// No ports; imported by icache and icache_frame_array.
package cpu_types_pkg;

  // Field widths for the default 16-frame cache.
  localparam int IIDX_W = 4;
  localparam int ITAG_W = 32 - IIDX_W - 2;

  // Fetch address broken into tag / frame index / byte offset (default frame count).
  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

endpackage

// File: rtl/icache_frame_array.sv
// Frame storage for the direct-mapped icache: valid bits, tags and one data word per frame.
// Latency: read port is combinational; write port commits on the rising clock edge.
// Backpressure: none; writes are always accepted. nRST asynchronously clears every valid bit.
// Ports: CLK, nRST; rd_idx -> rd_vld/rd_tag/rd_dat; wr_en with wr_idx/wr_tag/wr_dat.
module icache_frame_array
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16,
  parameter int IDX_W = $clog2(NSETS),
  parameter int TAG_W = 32 - IDX_W - 2
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_vld,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_dat,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_dat
);

  logic [NSETS-1:0] valid;
  logic [TAG_W-1:0] tags [NSETS];
  logic [31:0]      data [NSETS];

  // Only the valid bits need reset; tag/data are meaningless until valid is set.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_dat;
    end
  end

  assign rd_vld = valid[rd_idx];
  assign rd_tag = tags[rd_idx];
  assign rd_dat = data[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with a blocking fill FSM.
// Latency: hits are combinational (0 cycles); a miss costs 1 detect cycle + FETCH cycles, then hits.
// Backpressure: ihit low stalls the fetch; iwait high holds FETCH with iREN/iaddr stable.
// Ports: CLK, nRST; fetch side imemREN/imemaddr -> ihit/imemload; memory side iREN/iaddr <- iwait/iload.
// Optional: define ICACHE_STATS_EN to add the hit_count/miss_count statistics ports.
module icache
  import cpu_types_pkg::*;
#(
  parameter int NSETS = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
`ifdef ICACHE_STATS_EN
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
`endif
  input  logic        iwait,
  input  logic [31:0] iload
);

  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 32 - IDX_W - 2;

  icache_state_t    state;
  logic [31:0]      miss_addr;
  logic             iren_q;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic             frame_vld;
  logic [TAG_W-1:0] frame_tag;
  logic [31:0]      frame_dat;
  logic             lookup_hit;
  logic             fill_en;

  // Byte offset plays no part in word-aligned lookup.
  logic [1:0]       unused_bytoff;
  assign unused_bytoff = imemaddr[1:0];

  assign req_idx = imemaddr[IDX_W+1:2];
  assign req_tag = imemaddr[31:IDX_W+2];

  icache_frame_array #(
    .NSETS (NSETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_frames (
    .CLK    (CLK),
    .nRST   (nRST),
    .rd_idx (req_idx),
    .rd_vld (frame_vld),
    .rd_tag (frame_tag),
    .rd_dat (frame_dat),
    .wr_en  (fill_en),
    .wr_idx (miss_addr[IDX_W+1:2]),
    .wr_tag (miss_addr[31:IDX_W+2]),
    .wr_dat (iload)
  );

  assign lookup_hit = frame_vld && (frame_tag == req_tag);

  // The fill uses only the latched miss address, so changes on the fetch side
  // during FETCH cannot redirect or abort it.
  assign fill_en  = iren_q && !iwait;

  assign ihit     = (state == IDLE) && imemREN && lookup_hit;
  assign imemload = frame_dat;
  assign iREN     = iren_q;
  assign iaddr    = miss_addr;

  // iren_q mirrors "state == FETCH" as a register so iREN is glitch-free.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= IDLE;
      miss_addr <= '0;
      iren_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !lookup_hit) begin
            miss_addr <= imemaddr;
            iren_q    <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (!iwait) begin
            iren_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          iren_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q;
  logic [31:0] miss_q;

  // Counters wrap naturally at 32 bits.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else if (state == IDLE) begin
      if (ihit) begin
        hit_q <= hit_q + 32'd1;
      end
      if (imemREN && !lookup_hit) begin
        miss_q <= miss_q + 32'd1;
      end
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized fetches
// compared against an address-level cache model and a synthetic memory.
module tb_icache;

  localparam int NSETS = 16;
  localparam int IDX_W = $clog2(NSETS);

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  icache #(.NSETS(NSETS)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .imemREN    (imemREN),
    .imemaddr   (imemaddr),
    .ihit       (ihit),
    .imemload   (imemload),
    .iREN       (iREN),
    .iaddr      (iaddr),
`ifdef ICACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .iwait      (iwait),
    .iload      (iload)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: which word address each frame currently holds.
  bit          m_valid [NSETS];
  logic [31:0] m_addr  [NSETS];
  int unsigned m_hits   = 0;
  int unsigned m_misses = 0;

  function automatic int unsigned frame_of(input logic [31:0] a);
    return (a >> 2) % NSETS;
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    int unsigned f;
    f = frame_of(a);
    return m_valid[f] && ((m_addr[f] >> (2 + IDX_W)) == (a >> (2 + IDX_W)));
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C010004;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic check_stats();
`ifdef ICACHE_STATS_EN
    check("hit_count", hit_count, m_hits);
    check("miss_count", miss_count, m_misses);
`endif
  endtask

  task automatic model_clear();
    for (int i = 0; i < NSETS; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = '0;
    end
    m_hits   = 0;
    m_misses = 0;
  endtask

  // One fetch of address a, starting at a negedge. On a miss, memory holds
  // iwait high for nw cycles. With disturb set, the request is dropped and the
  // address moved during FETCH; the fill must still use a.
  task automatic fetch(input logic [31:0] a, input int nw, input bit disturb);
    bit exp_hit;
    exp_hit  = model_hit(a);
    imemREN  = 1'b1;
    imemaddr = a;
    iwait    = 1'b1;
    iload    = $urandom;
    #1;
    check_stats();
    check("lookup_ihit", 32'(ihit), 32'(exp_hit));
    check("idle_iren", 32'(iREN), 0);
    if (exp_hit) begin
      check("hit_data", imemload, mem_word(a));
      m_hits++;
      @(negedge CLK);
    end else begin
      m_misses++;
      @(negedge CLK);
      for (int k = 0; k <= nw; k++) begin
        if (disturb) begin
          imemREN  = 1'b0;
          imemaddr = a + 32'h4;
        end
        iwait = (k < nw);
        iload = (k < nw) ? $urandom : mem_word(a);
        #1;
        check("fetch_iren", 32'(iREN), 1);
        check("fetch_iaddr", iaddr, a);
        check("fetch_ihit", 32'(ihit), 0);
        @(negedge CLK);
      end
      iwait = 1'b1;
      iload = $urandom;
      m_valid[frame_of(a)] = 1'b1;
      m_addr[frame_of(a)]  = a;
      #1;
      check("post_fill_iren", 32'(iREN), 0);
      if (disturb) begin
        check("post_fill_noreq_ihit", 32'(ihit), 0);
      end else begin
        check("post_fill_ihit", 32'(ihit), 1);
        check("post_fill_data", imemload, mem_word(a));
        m_hits++;
      end
      @(negedge CLK);
    end
  endtask

  task automatic idle_cycle();
    imemREN  = 1'b0;
    imemaddr = $urandom & 32'hFFFF_FFFC;
    iwait    = 1'b1;
    #1;
    check("idle_ihit", 32'(ihit), 0);
    check("idle_iren", 32'(iREN), 0);
    check_stats();
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rst_addr;

    model_clear();
    nRST     = 1'b0;
    imemREN  = 1'b0;
    imemaddr = '0;
    iwait    = 1'b1;
    iload    = '0;
    repeat (2) @(negedge CLK);
    #1;
    check("reset_ihit", 32'(ihit), 0);
    check("reset_iren", 32'(iREN), 0);
    check("reset_iaddr", iaddr, 0);
    check_stats();
    imemREN = 1'b1;
    #1;
    check("reset_req_ihit", 32'(ihit), 0);
    @(negedge CLK);
    nRST    = 1'b1;
    imemREN = 1'b0;

    // First fill: iwait high 2 cycles -> iREN high 3 cycles, hit on the 4th cycle after request.
    fetch(32'h0000_0000, 2, 1'b0);
    // Refetch hits immediately.
    fetch(32'h0000_0000, 0, 1'b0);
    // Same-index conflict evicts and forces a refill.
    fetch(32'h0000_0040, 1, 1'b0);
    fetch(32'h0000_0000, 0, 1'b0);
    // Request dropped and address changed mid-fill; fill still installs 0x04.
    fetch(32'h0000_0004, 1, 1'b1);
    idle_cycle();
    fetch(32'h0000_0004, 0, 1'b0);

    // Randomized traffic over three tags per frame.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle_cycle();
      end else begin
        ra = ($urandom_range(0, 2) << (2 + IDX_W)) | ($urandom_range(0, NSETS - 1) << 2);
        fetch(ra, $urandom_range(0, 3), 1'b0);
      end
    end
    idle_cycle();

    // Reset asserted mid-FETCH: iREN drops at once, a late iload is ignored,
    // and everything previously cached misses afterwards.
    fetch(32'h0000_0000, 0, 1'b0);
    rst_addr = 32'h0000_0114;
    imemREN  = 1'b1;
    imemaddr = rst_addr;
    iwait    = 1'b1;
    #1;
    check("rst_req_ihit", 32'(ihit), 0);
    @(negedge CLK);
    #1;
    check("rst_fetch_iren", 32'(iREN), 1);
    nRST = 1'b0;
    #1;
    check("rst_async_iren", 32'(iREN), 0);
    check("rst_async_iaddr", iaddr, 0);
    imemREN = 1'b0;
    iwait   = 1'b0;
    iload   = mem_word(rst_addr);
    @(negedge CLK);
    @(negedge CLK);
    nRST  = 1'b1;
    iwait = 1'b1;
    model_clear();
    imemREN  = 1'b1;
    imemaddr = rst_addr;
    #1;
    check("rst_late_load_ignored", 32'(ihit), 0);
    imemREN = 1'b0;
    #1;
    check_stats();

    // After reset: one miss on 0x0, then three more hits on it.
    fetch(32'h0000_0000, 1, 1'b0);
    for (int i = 0; i < 3; i++) fetch(32'h0000_0000, 0, 1'b0);
    idle_cycle();
`ifdef ICACHE_STATS_EN
    check("stats_miss_total", miss_count, 1);
    check("stats_hit_total", hit_count, 4);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
